// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch and data-access channels. Data has priority; a saturating
// starvation counter forces a fetch through after STARVE_LIMIT consecutive
// data grants that were made while a fetch was waiting.
module sram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction-fetch channel
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data channel
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // SRAM port
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_PEND = 2'b01,
    D_PEND = 2'b10
  } resp_t;

  resp_t       resp_q, resp_d;
  logic [3:0]  starve_q, starve_d;
  logic        force_i;
  logic        grant_i;
  logic        grant_d;

  // Same-cycle grant: data wins unless the fetch has waited too long.
  // Both grants are held off while reset is asserted so nothing reaches
  // the SRAM during reset.
  always_comb begin
    force_i = inst_req & (starve_q == LIMIT);
    grant_d = resetn & data_req & ~force_i;
    grant_i = resetn & inst_req & ~grant_d;
  end

  assign inst_addr_ok = grant_i;
  assign data_addr_ok = grant_d;

  // Drive the SRAM port from whichever channel holds the grant.
  always_comb begin
    sram_en    = grant_i | grant_d;
    sram_addr  = 32'h0;
    sram_wen   = 4'h0;
    sram_wdata = 32'h0;
    if (grant_d) begin
      sram_addr  = data_addr;
      sram_wen   = data_wr ? data_wstrb : 4'h0;
      sram_wdata = data_wdata;
    end else if (grant_i) begin
      sram_addr  = inst_addr;
    end
  end

  // Next-state logic: the response owner for next cycle and the fetch
  // starvation count.
  always_comb begin
    resp_d   = IDLE;
    starve_d = starve_q;
    if (grant_i) begin
      resp_d = I_PEND;
    end else if (grant_d) begin
      resp_d = D_PEND;
    end

    if (grant_i || !inst_req) begin
      starve_d = 4'd0;
    end else if (grant_d) begin
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
    end
  end

  // State registers; reset drops any response still in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_q   <= IDLE;
      starve_q <= 4'd0;
    end else begin
      resp_q   <= resp_d;
      starve_q <= starve_d;
    end
  end

  // The SRAM read data is routed to the channel that owned last cycle's access.
  assign inst_data_ok = (resp_q == I_PEND);
  assign data_data_ok = (resp_q == D_PEND);
  assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural synchronous SRAM.
module tb_sram_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_wen     (sram_wen),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  typedef struct {
    logic        is_data;
    logic        chk_rd;
    logic [31:0] rd;
    int          due;
  } ent_t;

  ent_t sb[$];

  // SRAM model: unwritten words read back as addr ^ 0xFFFFFFFF.
  logic [31:0] mem [0:255];
  logic        wrt [0:255];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      wrt[i] = 1'b0;
    end
    sram_rdata = 32'h0;
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return wrt[a[9:2]] ? mem[a[9:2]] : (a ^ 32'hFFFFFFFF);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (sram_en) begin
      sram_rdata <= mem_rd(sram_addr);
      if (sram_wen != 4'h0) begin
        mem[sram_addr[9:2]] <= merge(mem_rd(sram_addr), sram_wdata, sram_wen);
        wrt[sram_addr[9:2]] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc_n) begin
      n_cmp++;
      n_err++;
      $display("FAIL missing_resp: got none expected %s response due cycle %0d",
               sb[0].is_data ? "data" : "inst", sb[0].due);
      void'(sb.pop_front());
    end
    if (inst_data_ok || data_data_ok) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got inst_ok=%b data_ok=%b expected none",
                 inst_data_ok, data_data_ok);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("resp_cycle", 32'(cyc_n), 32'(e.due));
        chk("inst_data_ok", 32'(inst_data_ok), 32'(!e.is_data));
        chk("data_data_ok", 32'(data_data_ok), 32'(e.is_data));
        if (e.chk_rd) begin
          if (e.is_data) chk("data_rdata", data_rdata, e.rd);
          else           chk("inst_rdata", inst_rdata, e.rd);
        end
        if (e.is_data) chk("inst_rdata_idle", inst_rdata, 32'h0);
        else           chk("data_rdata_idle", data_rdata, 32'h0);
      end
    end
  end

  // One cycle of stimulus with the hand-computed grant and response.
  task automatic cyc(input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [3:0] ds,
                     input logic [31:0] da, input logic [31:0] dwd,
                     input logic egi, input logic egd,
                     input logic [31:0] erd, input logic crd);
    ent_t e;
    inst_req   = ir;
    inst_addr  = ia;
    data_req   = dr;
    data_wr    = dw;
    data_wstrb = ds;
    data_addr  = da;
    data_wdata = dwd;
    @(negedge clk);
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(egi));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(egd));
    chk("sram_en", 32'(sram_en), 32'(egi | egd));
    if (egi || egd) begin
      chk("sram_addr", sram_addr, egd ? da : ia);
      chk("sram_wen", 32'(sram_wen), 32'((egd && dw) ? ds : 4'h0));
      if (egd) chk("sram_wdata", sram_wdata, dwd);
      e.is_data = egd;
      e.chk_rd  = crd;
      e.rd      = erd;
      e.due     = cyc_n + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_inst_addr_ok"}, 32'(inst_addr_ok), 32'h0);
    chk({tag, "_data_addr_ok"}, 32'(data_addr_ok), 32'h0);
    chk({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'h0);
    chk({tag, "_data_data_ok"}, 32'(data_data_ok), 32'h0);
    chk({tag, "_inst_rdata"}, inst_rdata, 32'h0);
    chk({tag, "_data_rdata"}, data_rdata, 32'h0);
    chk({tag, "_sram_en"}, 32'(sram_en), 32'h0);
    chk({tag, "_sram_wen"}, 32'(sram_wen), 32'h0);
    chk({tag, "_sram_addr"}, sram_addr, 32'h0);
    chk({tag, "_sram_wdata"}, sram_wdata, 32'h0);
  endtask

  initial begin
    // Reset with both requests active: every output must stay 0.
    resetn     = 1'b0;
    inst_req   = 1'b1;
    inst_addr  = 32'hBFC00000;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'hF;
    data_addr  = 32'h100;
    data_wdata = 32'h12345678;
    @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk);
    #1;
    inst_req = 1'b0;
    data_req = 1'b0;
    resetn   = 1'b1;

    // Fetch only, three back-to-back accesses.
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 32'hBFC00000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
          1'b1, 1'b0, 32'h403FFFFF, 1'b1);
    idle(1);

    // Data write then read back; then a zero-strobe write leaves memory intact.
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    idle(1);

    // Byte write into 0x11223344 with strobe 0x2.
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h200, 32'h11223344, 1'b0, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 4'h2, 32'h200, 32'h0000AA00, 1'b0, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0, 1'b0, 1'b1, 32'h1122AA44, 1'b1);
    idle(1);

    // Contention: D,D,D,D,I repeating.
    for (int k = 0; k < 10; k++) begin
      logic gi;
      gi = (k % 5 == 4);
      cyc(1'b1, 32'hBFC00000, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0,
          gi, !gi, gi ? 32'h403FFFFF : 32'hDEADBEEF, 1'b1);
    end
    idle(1);

    // Build up the starvation count, last cycle is an accepted data read.
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 32'hBFC00000, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0,
          1'b0, 1'b1, 32'hDEADBEEF, 1'b1);

    // Reset in the response cycle of that read: the response is dropped.
    resetn     = 1'b0;
    sb.delete();
    data_wr    = 1'b1;
    data_wstrb = 4'hF;
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // After release the counter starts from 0 again: D,D,D,D,I.
    for (int k = 0; k < 5; k++) begin
      logic gi;
      gi = (k == 4);
      cyc(1'b1, 32'hBFC00000, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0,
          gi, !gi, gi ? 32'h403FFFFF : 32'hDEADBEEF, 1'b1);
    end
    cyc(1'b1, 32'hBFC00000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
        1'b1, 1'b0, 32'h403FFFFF, 1'b1);
    idle(3);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM between the CPU instruction-fetch and data-access request channels. Each cycle it grants at most one requester, drives the SRAM port, and returns a response exactly one cycle later. Data accesses have priority, and a starvation limit guarantees that fetch makes progress. The block sits between the `mips` core and a unified SRAM, where the fetch and data ports would otherwise need separate memories.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive data grants allowed while `inst_req` is pending before fetch is forced through; legal range 1..15.
- `clk` in 1: system clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `inst_req` in 1: fetch request.
- `inst_addr` in 32: fetch byte address.
- `inst_addr_ok` out 1: fetch request accepted this cycle.
- `inst_data_ok` out 1: fetch response valid.
- `inst_rdata` out 32: fetch read data.
- `data_req` in 1: data request.
- `data_wr` in 1: 1 = write, 0 = read.
- `data_wstrb` in 4: byte write strobes.
- `data_addr` in 32: data byte address.
- `data_wdata` in 32: write data.
- `data_addr_ok` out 1: data request accepted this cycle.
- `data_data_ok` out 1: data response valid (read data or write ack).
- `data_rdata` out 32: data read data.
- `sram_en` out 1: SRAM enable.
- `sram_wen` out 4: SRAM byte write enables.
- `sram_addr` out 32: SRAM address.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data, valid the cycle after the access.

## Operation
- **Grant (combinational, same cycle):**
  - Let `force_i = inst_req & (starve_cnt == STARVE_LIMIT)`.
  - `grant_d = data_req & ~force_i`.
  - `grant_i = inst_req & ~grant_d`.
  - Both grants are 0 while `resetn` = 0.
- **Accept signals:** `inst_addr_ok = grant_i`; `data_addr_ok = grant_d`. A request is accepted when req & addr_ok are both high at a rising edge. Requesters hold req/addr/wdata stable until accepted.
- **SRAM drive:**
  - `sram_en = grant_i | grant_d`.
  - `sram_addr` = address of the granted channel, else 0.
  - `sram_wen = grant_d & data_wr ? data_wstrb : 4'h0`.
  - `sram_wdata = grant_d ? data_wdata : 0`.
- **Response register `resp`, 2 bits:**
  - States: IDLE, I_PEND, D_PEND.
  - Next state is I_PEND if `grant_i`, D_PEND if `grant_d`, else IDLE. Every state transitions every cycle.
- **Response outputs:**
  - `inst_data_ok = (resp == I_PEND)`.
  - `data_data_ok = (resp == D_PEND)`.
  - `inst_rdata = inst_data_ok ? sram_rdata : 0`.
  - `data_rdata = data_data_ok ? sram_rdata : 0`. For a write, this is the SRAM output for the written address and is ignored by the core.
- **Starvation counter `starve_cnt`:**
  - Width 4 bits.
  - Increments, saturating at `STARVE_LIMIT`, on each cycle with `grant_d & inst_req`.
  - Clears on `grant_i` or when `inst_req` = 0.
  - Holds otherwise.
- **No backpressure:** responses are never stalled, and requesters must consume `data_ok` in the cycle it is asserted.
- **Write with `data_wstrb` = 0:** issued normally, with `sram_en` = 1 and `sram_wen` = 0. It still produces `data_data_ok`.

## Timing
- **Reset:**
  - `resp` = IDLE and `starve_cnt` = 0 asynchronously.
  - While in reset, all outputs are 0.
- **Latency:** accept in cycle N; response in cycle N+1.
- **Throughput:** one access per cycle. A new grant in cycle N+1 overlaps the N response.
- **Simultaneous requests:** `data_req` and `inst_req` both high resolves to data, except when `force_i` = 1, which resolves to inst.
- **Bounded fetch wait:** with continuous data requests, fetch is granted at least once every `STARVE_LIMIT`+1 cycles.
- **Reset mid-operation:** a pending response is dropped and no `data_ok` is issued after reset release. The first grant is possible in the first cycle with `resetn` = 1.
- **Address alignment:** addresses pass through unchanged. Alignment is the requester's responsibility.

## Test plan
- **Fetch only:** `inst_req` = 1 at `inst_addr` 0xBFC00000 for 3 cycles, SRAM model returning addr^0xFFFFFFFF.
  - `inst_addr_ok` is high each cycle.
  - `inst_data_ok` is high cycles 2-4, with `inst_rdata` = 0x403FFFFF.
- **Data write then read:**
  - Write to 0x100 with `data_wstrb` = 0xF and `data_wdata` = 0xDEADBEEF: `sram_wen` = 0xF, `data_data_ok` next cycle.
  - Read from 0x100: `data_rdata` = 0xDEADBEEF one cycle after accept.
- **Contention, `STARVE_LIMIT` = 4:** both requests held high continuously.
  - Grant pattern is D,D,D,D,I repeating.
  - `inst_addr_ok` is high on every 5th cycle.
- **Byte write:** memory word 0x11223344, write `data_wstrb` = 0x2 with `data_wdata` = 0x0000AA00, then read back. Result is 0x1122AA44.
- **Reset mid-operation:** assert `resetn` = 0 in the cycle right after a data read is accepted.
  - All outputs go to 0 immediately.
  - No `data_data_ok` after release.
  - `starve_cnt` is 0, so a fetch-only request is granted in the first cycle after release.
